// File: rtl/aes_mode_engine.sv
// ECB/CBC/CTR mode sequencer wrapped around an ECB-only block cipher core.
// One block is in flight at a time: load, kick the core, wait for its result, emit.
module aes_mode_engine #(
  parameter int DATA_W = 128,
  parameter int KEY_W  = 128,
  parameter int CTR_W  = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rs,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              dir,
  input  logic [KEY_W-1:0]  key,
  input  logic [DATA_W-1:0] iv,
  input  logic [CNT_W-1:0]  nblocks,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              core_start,
  output logic              core_dir,
  output logic [KEY_W-1:0]  core_key,
  output logic [DATA_W-1:0] core_din,
  input  logic [DATA_W-1:0] core_dout,
  input  logic              core_ready,
  output logic [2:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid and its data never depend combinationally on ready.

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_KICK = 3'd2,
    S_WAIT = 3'd3,
    S_EMIT = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [1:0]        MODE_ECB = 2'b00;
  localparam logic [1:0]        MODE_CBC = 2'b01;
  localparam logic [1:0]        MODE_CTR = 2'b10;
  localparam logic [1:0]        MODE_ILL = 2'b11;
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ZERO = '0;
  localparam logic [CTR_W-1:0]  CTR_ONE  = {{(CTR_W-1){1'b0}}, 1'b1};

  state_t state_q, state_d;

  logic [1:0]        mode_q;
  logic              dir_q;
  logic [KEY_W-1:0]  key_q;
  logic [CNT_W-1:0]  remain_q;
  logic [DATA_W-1:0] chain_q;
  logic [DATA_W-1:0] ctr_q;
  logic [DATA_W-1:0] blk_q;
  logic [DATA_W-1:0] core_din_q;
  logic [DATA_W-1:0] out_data_q;
  logic              first_wait_q;
  logic              err_q;

  logic accept_start;
  logic take_in;
  logic take_core;
  logic take_out;

  assign accept_start = (state_q == S_IDLE) && start && (mode != MODE_ILL);
  assign take_in      = (state_q == S_LOAD) && in_valid;
  // The first WAIT cycle may still see core_ready left over from the previous block.
  assign take_core    = (state_q == S_WAIT) && !first_wait_q && core_ready;
  assign take_out     = (state_q == S_EMIT) && out_ready;

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    core_start = 1'b0;
    done       = 1'b0;
    busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    unique case (state_q)
      S_IDLE: begin
        if (accept_start) state_d = (nblocks == CNT_ZERO) ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_KICK;
      end
      S_KICK: begin
        core_start = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (take_core) state_d = S_EMIT;
      end
      S_EMIT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = (remain_q == CNT_ONE) ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      mode_q       <= MODE_ECB;
      dir_q        <= 1'b0;
      key_q        <= '0;
      remain_q     <= '0;
      chain_q      <= '0;
      ctr_q        <= '0;
      blk_q        <= '0;
      core_din_q   <= '0;
      out_data_q   <= '0;
      first_wait_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      err_q        <= (state_q == S_IDLE) && start && (mode == MODE_ILL);
      first_wait_q <= (state_q == S_KICK);
      if (accept_start) begin
        mode_q   <= mode;
        dir_q    <= dir;
        key_q    <= key;
        remain_q <= nblocks;
        chain_q  <= iv;
        ctr_q    <= iv;
      end
      if (take_in) begin
        blk_q <= in_data;
        unique case (mode_q)
          MODE_CBC: core_din_q <= dir_q ? in_data : (in_data ^ chain_q);
          MODE_CTR: core_din_q <= ctr_q;
          default:  core_din_q <= in_data;
        endcase
      end
      if (take_core) begin
        unique case (mode_q)
          MODE_CBC: begin
            if (!dir_q) begin
              out_data_q <= core_dout;
              chain_q    <= core_dout;
            end else begin
              out_data_q <= core_dout ^ chain_q;
              chain_q    <= blk_q;
            end
          end
          MODE_CTR: begin
            out_data_q         <= core_dout ^ blk_q;
            // Only the low counter field rolls over; the nonce part is fixed for the job.
            ctr_q[CTR_W-1:0]   <= ctr_q[CTR_W-1:0] + CTR_ONE;
          end
          default: out_data_q <= core_dout;
        endcase
      end
      if (take_out) remain_q <= remain_q - CNT_ONE;
    end
  end

  assign out_data  = out_data_q;
  assign out_last  = (state_q == S_EMIT) && (remain_q == CNT_ONE);
  assign err       = err_q;
  assign core_key  = key_q;
  assign core_din  = core_din_q;
  assign core_dir  = dir_q && (mode_q != MODE_CTR);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_aes_mode_engine.sv
// Bench for aes_mode_engine: stub cipher core, job-level chaining model, directed vectors.
module tb_aes_mode_engine;

  localparam int DW  = 128;
  localparam int KW  = 128;
  localparam int NW  = 16;
  localparam int LAT = 5;

  localparam logic [127:0] AES_K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] AES_P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] AES_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic          clk = 1'b0;
  logic          rs = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          dir = 1'b0;
  logic [KW-1:0] key = '0;
  logic [DW-1:0] iv = '0;
  logic [NW-1:0] nblocks = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy, done, err, core_start, core_dir;
  logic [KW-1:0] core_key;
  logic [DW-1:0] core_din;
  logic [DW-1:0] core_dout = '0;
  logic          core_ready = 1'b0;
  logic [2:0]    dbg_state;

  aes_mode_engine dut (
    .clk(clk), .rs(rs), .start(start), .mode(mode), .dir(dir), .key(key), .iv(iv),
    .nblocks(nblocks), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .err(err), .core_start(core_start), .core_dir(core_dir),
    .core_key(core_key), .core_din(core_din), .core_dout(core_dout),
    .core_ready(core_ready), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- stub core ----------------
  // XOR-with-key cipher, except the known AES-128 vector; core_ready stays high
  // (stale) for one cycle after a new start, then drops until the new result.
  function automatic logic [127:0] core_f(input logic [127:0] d, input logic [127:0] k);
    if (k == AES_K && d == AES_P) return AES_C;
    return d ^ k;
  endfunction

  logic [3:0]   st_cnt = '0;
  logic [127:0] st_din = '0;
  logic [127:0] st_key = '0;
  always @(posedge clk) begin
    if (core_start) begin
      st_cnt <= 4'(LAT);
      st_din <= core_din;
      st_key <= core_key;
    end else if (st_cnt != 0) begin
      st_cnt <= st_cnt - 4'd1;
      if (st_cnt == 4'd1) begin
        core_ready <= 1'b1;
        core_dout  <= core_f(st_din, st_key);
      end else begin
        core_ready <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_fail = 0;

  logic [DW-1:0] exp_din_q[$];
  logic [DW-1:0] exp_q[$];
  logic          exp_last_q[$];
  logic [KW-1:0] exp_key = '0;
  logic          exp_dir = 1'b0;
  logic [DW-1:0] got_out[$];
  logic [DW-1:0] got_din[$];
  logic [DW-1:0] job_blk[8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: event not as expected", name);
  endtask

  // Chaining model straight from the mode definitions.
  task automatic model_job(input logic [1:0] m, input logic d, input logic [127:0] k,
                           input logic [127:0] v, input int n);
    logic [127:0] c, t, din, o;
    c = v;
    t = v;
    for (int i = 0; i < n; i++) begin
      case (m)
        2'b01: begin
          if (!d) begin
            din = job_blk[i] ^ c;
            o   = core_f(din, k);
            c   = o;
          end else begin
            din = job_blk[i];
            o   = core_f(din, k) ^ c;
            c   = job_blk[i];
          end
        end
        2'b10: begin
          din = t;
          o   = core_f(t, k) ^ job_blk[i];
          t[31:0] = t[31:0] + 32'd1;
        end
        default: begin
          din = job_blk[i];
          o   = core_f(din, k);
        end
      endcase
      exp_din_q.push_back(din);
      exp_q.push_back(o);
      exp_last_q.push_back(i == n - 1);
    end
    exp_key = k;
    exp_dir = (m == 2'b10) ? 1'b0 : d;
  endtask

  logic          hold_v = 1'b0;
  logic [DW-1:0] hold_d = '0;
  logic          hold_l = 1'b0;

  always @(negedge clk) begin
    if (rs) begin
      if (core_start) begin
        got_din.push_back(core_din);
        if (exp_din_q.size() == 0) note_fail("core_start_unexpected");
        else begin
          check("core_din", core_din, exp_din_q.pop_front());
          check("core_key", core_key, exp_key);
          check("core_dir", {127'd0, core_dir}, {127'd0, exp_dir});
        end
      end
      if (out_valid && hold_v) begin
        check("out_hold_data", out_data, hold_d);
        check("out_hold_last", {127'd0, out_last}, {127'd0, hold_l});
      end
      if (out_valid && out_ready) begin
        got_out.push_back(out_data);
        if (exp_q.size() == 0) note_fail("out_unexpected");
        else begin
          check("out_data", out_data, exp_q.pop_front());
          check("out_last", {127'd0, out_last}, {127'd0, exp_last_q.pop_front()});
        end
      end
      if (in_ready && out_valid) note_fail("in_ready_during_emit");
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
      hold_l = out_last;
    end else begin
      hold_v = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic launch(input logic [1:0] m, input logic d, input logic [127:0] k,
                        input logic [127:0] v, input int n);
    @(negedge clk);
    mode = m; dir = d; key = k; iv = v; nblocks = NW'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_blocks(input int n);
    for (int i = 0; i < n; i++) begin
      int w;
      in_data  = job_blk[i];
      in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 300) begin
        @(negedge clk);
        w++;
      end
      if (!in_ready) begin
        note_fail("in_ready_timeout");
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int w;
    w = 0;
    while (!done && w < 400) begin
      @(negedge clk);
      w++;
    end
    check("done_seen", {127'd0, done}, 128'd1);
    check("busy_at_done", {127'd0, busy}, 128'd0);
    @(negedge clk);
    check("done_width", {127'd0, done}, 128'd0);
  endtask

  task automatic run_job(input logic [1:0] m, input logic d, input logic [127:0] k,
                         input logic [127:0] v, input int n);
    model_job(m, d, k, v, n);
    got_out.delete();
    got_din.delete();
    launch(m, d, k, v, n);
    send_blocks(n);
    wait_done();
    check("exp_drained", 128'(exp_q.size()), 128'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {120'd0, in_ready, out_valid, out_last, busy, done, err, core_start,
                          core_dir}, 128'd0);
    check({tag, "_out_data"}, out_data, 128'd0);
    check({tag, "_core_key"}, core_key, 128'd0);
    check({tag, "_core_din"}, core_din, 128'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 0);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int w;
    logic [127:0] held;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rs = 1'b1;
    repeat (2) @(negedge clk);

    // Known AES-128 vector through ECB, with explicit done timing.
    job_blk[0] = AES_P;
    model_job(2'b00, 1'b0, AES_K, 128'd0, 1);
    launch(2'b00, 1'b0, AES_K, 128'd0, 1);
    send_blocks(1);
    w = 0;
    while (!out_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("aes_out_data", out_data, AES_C);
    check("aes_out_last", {127'd0, out_last}, 128'd1);
    @(negedge clk);
    check("aes_done_next", {127'd0, done}, 128'd1);
    @(negedge clk);
    check("aes_done_width", {127'd0, done}, 128'd0);

    // CBC round trip with a zero key.
    job_blk[0] = 128'd0; job_blk[1] = 128'd0;
    run_job(2'b01, 1'b0, 128'd0, 128'd1, 2);
    check("cbc_enc_lit0", got_out[0], 128'd1);
    check("cbc_enc_lit1", got_out[1], 128'd1);
    job_blk[0] = 128'd1; job_blk[1] = 128'd1;
    run_job(2'b01, 1'b1, 128'd0, 128'd1, 2);
    check("cbc_dec_lit0", got_out[0], 128'd0);
    check("cbc_dec_lit1", got_out[1], 128'd0);

    // CTR wrap of the low 32 bits; dir is ignored.
    job_blk[0] = 128'h0f0e0d0c0b0a09080706050403020100;
    job_blk[1] = 128'hffeeddccbbaa99887766554433221100;
    run_job(2'b10, 1'b1, 128'h2b7e151628aed2a6abf7158809cf4f3c,
            128'hdeadbeefcafef00d12345678ffffffff, 2);
    check("ctr_din0", got_din[0], 128'hdeadbeefcafef00d12345678ffffffff);
    check("ctr_din1", got_din[1], 128'hdeadbeefcafef00d1234567800000000);

    // Multi-block ECB decrypt and CBC encrypt with distinct data.
    job_blk[0] = 128'h1111; job_blk[1] = 128'h2222_0000; job_blk[2] = 128'h3;
    run_job(2'b00, 1'b1, 128'h5555_aaaa, 128'd0, 3);
    job_blk[0] = 128'h0123456789abcdef; job_blk[1] = 128'hfedcba9876543210;
    job_blk[2] = 128'h00ff00ff; job_blk[3] = 128'h1;
    run_job(2'b01, 1'b0, 128'h600df00d, 128'h1357_9bdf, 4);

    // Backpressure on the second output block.
    job_blk[0] = 128'ha1; job_blk[1] = 128'hb2; job_blk[2] = 128'hc3;
    model_job(2'b01, 1'b0, 128'h77, 128'h99, 3);
    launch(2'b01, 1'b0, 128'h77, 128'h99, 3);
    fork
      send_blocks(3);
      begin
        int seen;
        seen = 0;
        w = 0;
        while (seen < 2 && w < 200) begin
          @(posedge clk);
          #1;
          if (out_valid) seen++;
          if (seen == 1) while (out_valid && w < 200) begin @(posedge clk); #1; w++; end
          w++;
        end
        out_ready = 1'b0;
        held = out_data;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          check("bp_valid", {127'd0, out_valid}, 128'd1);
          check("bp_data", out_data, held);
          check("bp_in_ready", {127'd0, in_ready}, 128'd0);
          check("bp_core_start", {127'd0, core_start}, 128'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_done();
    check("bp_drained", 128'(exp_q.size()), 128'd0);

    // Illegal mode start.
    @(negedge clk);
    mode = 2'b11; nblocks = 16'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("err_pulse", {127'd0, err}, 128'd1);
    check("err_busy", {127'd0, busy}, 128'd0);
    @(negedge clk);
    check("err_width", {127'd0, err}, 128'd0);
    check("err_busy_after", {127'd0, busy}, 128'd0);

    // Zero-length job.
    @(negedge clk);
    mode = 2'b00; nblocks = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("zero_done", {127'd0, done}, 128'd1);
    check("zero_busy", {127'd0, busy}, 128'd0);
    @(negedge clk);
    check("zero_done_width", {127'd0, done}, 128'd0);

    // Start while busy is ignored.
    job_blk[0] = 128'h42; job_blk[1] = 128'h43;
    model_job(2'b00, 1'b0, 128'h9, 128'd0, 2);
    launch(2'b00, 1'b0, 128'h9, 128'd0, 2);
    fork
      send_blocks(2);
      begin
        repeat (3) @(negedge clk);
        mode = 2'b11; nblocks = 16'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_start_no_err", {127'd0, err}, 128'd0);
        check("busy_start_busy", {127'd0, busy}, 128'd1);
      end
    join
    wait_done();
    check("busy_start_drained", 128'(exp_q.size()), 128'd0);

    // Reset during WAIT.
    job_blk[0] = 128'hdead;
    model_job(2'b00, 1'b0, 128'hbeef, 128'd0, 1);
    launch(2'b00, 1'b0, 128'hbeef, 128'd0, 1);
    send_blocks(1);
    w = 0;
    while (!core_start && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("rst_core_start_seen", {127'd0, core_start}, 128'd1);
    repeat (2) @(negedge clk);
    #1 rs = 1'b0;
    #1 check_all_zero("midrst");
    exp_q.delete();
    exp_last_q.delete();
    exp_din_q.delete();
    @(negedge clk);
    rs = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midrst_quiet", {126'd0, done, out_valid}, 128'd0);
    end
    job_blk[0] = 128'h0badc0de;
    run_job(2'b00, 1'b0, 128'h1000, 128'd0, 1);
    check("post_rst_lit", got_out[0], 128'h0badd0de);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
